// File: rtl/struct_record_pkg.sv
// Shared record type, default widths and parity helper for struct_record_fifo.
// Optional head-parity checking is enabled with STRUCT_RECORD_PARITY_EN.
`ifndef STRUCT_RECORD_PKG_SV
`define STRUCT_RECORD_PKG_SV

// Declares a {xx, yy, zz} record struct for arbitrary widths inside a parametrised scope.
`define STRUCT_RECORD_T(name, xw, zw) \
  typedef struct packed { \
    logic [(xw)-1:0] xx; \
    logic            yy; \
    logic [(zw)-1:0] zz; \
  } name;

package struct_record_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_XX_W  = 8;
  localparam int DEF_ZZ_W  = 16;
  // Widest record the parity helper covers; narrower records are zero-extended.
  localparam int PAR_MAX_W = 64;

  `STRUCT_RECORD_T(record_t, DEF_XX_W, DEF_ZZ_W)

  function automatic logic rec_parity(input logic [PAR_MAX_W-1:0] bits);
    return ^bits;
  endfunction
endpackage

`endif

// File: rtl/struct_record_mem.sv
// DEPTH x record register array: full-record write, zz-only write, async read.
// Parity storage exists only when STRUCT_RECORD_PARITY_EN is defined.
module struct_record_mem
  import struct_record_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int XX_W  = DEF_XX_W,
  parameter int ZZ_W  = DEF_ZZ_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int RW   = XX_W + 1 + ZZ_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [RW-1:0]   wr_rec,
  input  logic            zz_en,
  input  logic [AW-1:0]   zz_addr,
  input  logic [ZZ_W-1:0] zz_data,
`ifdef STRUCT_RECORD_PARITY_EN
  input  logic            wr_par,
  input  logic            zz_par,
  output logic            rd_par,
`endif
  input  logic [AW-1:0]   rd_addr,
  output logic [RW-1:0]   rd_rec
);
  `STRUCT_RECORD_T(rec_t, XX_W, ZZ_W)

  rec_t mem_q [DEPTH];

  // The two write ports never target the same entry; the top guarantees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) mem_q[wr_addr] <= wr_rec;
      if (zz_en) mem_q[zz_addr].zz <= zz_data;
    end
  end

  assign rd_rec = mem_q[rd_addr];

`ifdef STRUCT_RECORD_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= '0;
    end else begin
      if (wr_en) par_q[wr_addr] <= wr_par;
      if (zz_en) par_q[zz_addr] <= zz_par;
    end
  end

  assign rd_par = par_q[rd_addr];
`endif
endmodule

// File: rtl/struct_record_fifo.sv
// Valid/ready record FIFO with an in-place patch port for the head entry's zz tag.
// Define STRUCT_RECORD_PARITY_EN to store and check an even-parity bit per entry.
module struct_record_fifo
  import struct_record_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int XX_W  = DEF_XX_W,
  parameter int ZZ_W  = DEF_ZZ_W,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XX_W-1:0] in_xx,
  input  logic            in_yy,
  input  logic [ZZ_W-1:0] in_zz,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XX_W-1:0] out_xx,
  output logic            out_yy,
  output logic [ZZ_W-1:0] out_zz,
  input  logic            patch_valid,
  input  logic [ZZ_W-1:0] patch_zz,
  output logic            patch_lost,
  output logic [CW-1:0]   count,
  output logic            out_perr
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = XX_W + 1 + ZZ_W;

  `STRUCT_RECORD_T(rec_t, XX_W, ZZ_W)

  // Handshake: a transfer happens on a side exactly when valid && ready in the same
  // cycle; ready depends only on registered occupancy, never on the other side.
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          patch_lost_q;
  logic          push, pop, patch_ok;
  rec_t          in_rec, head;
  logic [RW-1:0] head_bits;

  assign in_ready  = count_q < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign patch_ok  = patch_valid & out_valid & ~pop;
  assign in_rec    = {in_xx, in_yy, in_zz};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      patch_lost_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      patch_lost_q <= patch_valid & ~patch_ok;
    end
  end

`ifdef STRUCT_RECORD_PARITY_EN
  logic wr_par, zz_par, rd_par;
  rec_t patched;

  assign patched  = {head.xx, head.yy, patch_zz};
  assign wr_par   = rec_parity(PAR_MAX_W'(in_rec));
  assign zz_par   = rec_parity(PAR_MAX_W'(patched));
  assign out_perr = out_valid & (rec_parity(PAR_MAX_W'(head)) != rd_par);
`else
  assign out_perr = 1'b0;
`endif

  struct_record_mem #(
    .DEPTH (DEPTH),
    .XX_W  (XX_W),
    .ZZ_W  (ZZ_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_rec  (in_rec),
    .zz_en   (patch_ok),
    .zz_addr (rd_ptr),
    .zz_data (patch_zz),
`ifdef STRUCT_RECORD_PARITY_EN
    .wr_par  (wr_par),
    .zz_par  (zz_par),
    .rd_par  (rd_par),
`endif
    .rd_addr (rd_ptr),
    .rd_rec  (head_bits)
  );

  assign head       = head_bits;
  assign out_xx     = head.xx;
  assign out_yy     = head.yy;
  assign out_zz     = head.zz;
  assign patch_lost = patch_lost_q;
  assign count      = count_q;
endmodule

// File: tb/tb_struct_record_fifo.sv
// Bench for struct_record_fifo: queue-based record model, per-cycle compare, directed and random traffic.
module tb_struct_record_fifo;
  localparam int DEPTH = 4;
  localparam int XX_W  = 8;
  localparam int ZZ_W  = 16;
  localparam int RW    = XX_W + 1 + ZZ_W;
  localparam int CW    = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0, in_ready;
  logic [XX_W-1:0] in_xx = '0;
  logic            in_yy = 1'b0;
  logic [ZZ_W-1:0] in_zz = '0;
  logic            out_valid, out_ready = 1'b0;
  logic [XX_W-1:0] out_xx;
  logic            out_yy;
  logic [ZZ_W-1:0] out_zz;
  logic            patch_valid = 1'b0;
  logic [ZZ_W-1:0] patch_zz = '0;
  logic            patch_lost;
  logic [CW-1:0]   count;
  logic            out_perr;

  struct_record_fifo #(.DEPTH(DEPTH), .XX_W(XX_W), .ZZ_W(ZZ_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_xx(in_xx), .in_yy(in_yy), .in_zz(in_zz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_xx(out_xx), .out_yy(out_yy), .out_zz(out_zz),
    .patch_valid(patch_valid), .patch_zz(patch_zz), .patch_lost(patch_lost),
    .count(count), .out_perr(out_perr)
  );

  // scoreboard
  logic [RW-1:0] exp_q[$];
  logic          exp_lost = 1'b0;
  int            checks = 0;
  int            errors = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a queue of records, updated from the inputs at each rising edge
  always @(posedge clk) begin
    bit            mpush, mpop;
    logic [RW-1:0] h;
    if (rst) begin
      exp_q.delete();
      exp_lost = 1'b0;
    end else begin
      mpush    = in_valid && (exp_q.size() < DEPTH);
      mpop     = (exp_q.size() != 0) && out_ready;
      exp_lost = patch_valid && (mpop || exp_q.size() == 0);
      if (patch_valid && !exp_lost) begin
        h = exp_q[0];
        h[ZZ_W-1:0] = patch_zz;
        exp_q[0] = h;
      end
      if (mpop) void'(exp_q.pop_front());
      if (mpush) exp_q.push_back({in_xx, in_yy, in_zz});
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), exp_q.size());
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      chk("patch_lost", 32'(patch_lost), 32'(exp_lost));
      chk("out_perr", 32'(out_perr), 0);
      if (exp_q.size() != 0) chk("head", 32'({out_xx, out_yy, out_zz}), 32'(exp_q[0]));
    end
  end

  // driver
  task automatic drive(input logic iv, input logic [XX_W-1:0] xx, input logic y,
                       input logic [ZZ_W-1:0] zz, input logic ordy,
                       input logic pv, input logic [ZZ_W-1:0] pz);
    in_valid = iv; in_xx = xx; in_yy = y; in_zz = zz;
    out_ready = ordy; patch_valid = pv; patch_zz = pz;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // reset then idle
    idle();
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_fields", 32'({out_xx, out_yy, out_zz}), 0);
    chk("rst_patch_lost", 32'(patch_lost), 0);

    // two pushes, then two pops
    drive(1'b1, 8'h11, 1'b1, 16'd100, 1'b0, 1'b0, '0);
    drive(1'b1, 8'h22, 1'b0, 16'd200, 1'b0, 1'b0, '0);
    chk("two_count", 32'(count), 2);
    chk("two_head_xx", 32'(out_xx), 32'h11);
    chk("two_head_yy", 32'(out_yy), 1);
    chk("two_head_zz", 32'(out_zz), 100);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("pop1_xx", 32'(out_xx), 32'h22);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("pop2_count", 32'(count), 0);

    // fill, then push+pop while full
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, 8'(i), 1'(i), 16'(i * 10), 1'b0, 1'b0, '0);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 4);
    drive(1'b1, 8'd5, 1'b0, 16'd50, 1'b1, 1'b0, '0);
    chk("full_pp_count", 32'(count), 3);
    chk("full_pp_head", 32'(out_xx), 2);
    repeat (3) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);

    // patch the head
    drive(1'b1, 8'h33, 1'b1, 16'd100, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 16'd50);
    chk("patch_zz", 32'(out_zz), 50);
    chk("patch_xx", 32'(out_xx), 32'h33);
    chk("patch_yy", 32'(out_yy), 1);
    chk("patch_not_lost", 32'(patch_lost), 0);

    // lost patches: during pop, while empty, with push into empty
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 16'd77);
    chk("lost_pop", 32'(patch_lost), 1);
    idle();
    chk("lost_pulse_end", 32'(patch_lost), 0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 16'd9);
    chk("lost_empty", 32'(patch_lost), 1);
    drive(1'b1, 8'h44, 1'b0, 16'd300, 1'b0, 1'b1, 16'd999);
    chk("lost_push_empty", 32'(patch_lost), 1);
    chk("lost_push_zz", 32'(out_zz), 300);
    drive(1'b1, 8'h55, 1'b1, 16'd400, 1'b0, 1'b1, 16'd123);
    chk("push_patch_zz", 32'(out_zz), 123);
    chk("push_patch_count", 32'(count), 2);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("tail_untouched", 32'(out_zz), 400);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);

    // random traffic with resets mid-stream
    for (int c = 0; c < 300; c++) begin
      rst = (c == 100 || c == 220);
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 16'($urandom_range(0, 65535)));
      if (rst) begin
        chk("midrst_count", 32'(count), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
      end
    end
    rst = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
